// File: rtl/ps2_cmd_pkg.sv
// Shared encodings for the PS/2 command scheduler: FSM states, requester IDs
// and the keyboard command/response bytes.
package ps2_cmd_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_TX_START, S_TX_END, S_RSP_WAIT,
    S_NEXT, S_DONE, S_ERR, S_BOOT, S_BAT_WAIT
  } state_t;

  typedef enum logic [1:0] {REQ_CPU, REQ_LED, REQ_BOOT} req_id_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT      = 8'hAA;

endpackage

// File: rtl/ps2_rsp_timer.sv
// Loadable down-counter: start loads load_val and runs, clear stops it,
// expired is high while running with the count at zero.
module ps2_rsp_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic         run;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= load_val;
    end else if (run && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Shares the PS/2 host-to-keyboard transmitter between CPU writes and the LED
// updater, with ack/resend/timeout handling. Define PS2_BOOT_RESET_EN to send
// a keyboard reset (0xFF, then wait for 0xAA) after rst.
module ps2_cmd_scheduler
  import ps2_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 560000,
  parameter int START_CYCLES   = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_data,
  input  logic       cpu_load,
  output logic       cpu_busy,
  output logic       cpu_error,
  input  logic [2:0] led_state,
  input  logic       led_req,
  output logic       led_error,
  output logic [7:0] tx_data,
  output logic       tx_load,
  input  logic       tx_busy,
  input  logic       tx_error,
  input  logic       rx_valid,
  input  logic [7:0] rx_code,
  output logic       rx_pass,
  output logic       busy
);

`ifdef PS2_BOOT_RESET_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES * 50 + 1);
`else
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`endif
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t         state, state_n;
  req_id_t        owner, last_grant;
  logic [7:0]     cpu_byte, cur_byte;
  logic           cpu_pend, led_pend, led_stage;
  logic [RW-1:0]  retry;

  logic           grant_cpu, grant_led, boot_go, retry_inc, led_step;
  logic           t_start, t_clear, t_expired;
  logic [TW-1:0]  t_val;

  ps2_rsp_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (t_clear),
    .start    (t_start),
    .load_val (t_val),
    .expired  (t_expired)
  );

  always_comb begin
    state_n   = state;
    grant_cpu = 1'b0;
    grant_led = 1'b0;
    boot_go   = 1'b0;
    retry_inc = 1'b0;
    led_step  = 1'b0;
    t_start   = 1'b0;
    t_clear   = 1'b0;
    t_val     = TW'(TIMEOUT_CYCLES);
    case (state)
      S_IDLE: begin
        // On a tie the requester granted last time loses.
        if (cpu_pend && (!led_pend || last_grant == REQ_LED)) begin
          grant_cpu = 1'b1;
          state_n   = S_LOAD;
        end else if (led_pend) begin
          grant_led = 1'b1;
          state_n   = S_LOAD;
        end
      end
      S_BOOT: begin
        boot_go = 1'b1;
        state_n = S_LOAD;
      end
      S_LOAD: begin
        t_start = 1'b1;
        t_val   = TW'(START_CYCLES);
        state_n = S_TX_START;
      end
      S_TX_START: begin
        if (tx_busy) begin
          t_clear = 1'b1;
          state_n = S_TX_END;
        end else if (t_expired) begin
          state_n = S_ERR;
        end
      end
      S_TX_END: begin
        if (!tx_busy) begin
          if (tx_error) state_n = S_ERR;
          else begin
            t_start = 1'b1;
            state_n = S_RSP_WAIT;
          end
        end
      end
      S_RSP_WAIT: begin
        // A received byte takes precedence over a same-cycle timeout.
        if (rx_valid) begin
          if (rx_code == RSP_ACK) state_n = S_NEXT;
          else if (rx_code == RSP_RESEND) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry_inc = 1'b1;
              state_n   = S_LOAD;
            end else begin
              state_n = S_ERR;
            end
          end
        end else if (t_expired) begin
          state_n = S_ERR;
        end
      end
      S_NEXT: begin
        if (owner == REQ_LED && !led_stage) begin
          led_step = 1'b1;
          state_n  = S_LOAD;
        end
`ifdef PS2_BOOT_RESET_EN
        else if (owner == REQ_BOOT) begin
          t_start = 1'b1;
          t_val   = TW'(TIMEOUT_CYCLES * 50);
          state_n = S_BAT_WAIT;
        end
`endif
        else state_n = S_DONE;
      end
      S_BAT_WAIT: begin
        if (rx_valid && rx_code == RSP_BAT) state_n = S_DONE;
        else if (t_expired) state_n = S_ERR;
      end
      S_DONE: begin
        t_clear = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        t_clear = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef PS2_BOOT_RESET_EN
      state <= S_BOOT;
`else
      state <= S_IDLE;
`endif
      owner      <= REQ_CPU;
      last_grant <= REQ_LED;
      cpu_byte   <= 8'h00;
      cur_byte   <= 8'h00;
      cpu_pend   <= 1'b0;
      led_pend   <= 1'b0;
      led_stage  <= 1'b0;
      retry      <= '0;
      cpu_busy   <= 1'b0;
      cpu_error  <= 1'b0;
      led_error  <= 1'b0;
      tx_data    <= 8'h00;
      tx_load    <= 1'b0;
    end else begin
      state   <= state_n;
      tx_load <= (state == S_LOAD);
      if (state == S_LOAD) tx_data <= cur_byte;

      if (cpu_load && !cpu_busy) begin
        cpu_byte  <= cpu_data;
        cpu_pend  <= 1'b1;
        cpu_busy  <= 1'b1;
        cpu_error <= 1'b0;
      end

      if (grant_cpu) begin
        owner      <= REQ_CPU;
        last_grant <= REQ_CPU;
        cur_byte   <= cpu_byte;
        cpu_pend   <= 1'b0;
        led_stage  <= 1'b0;
        retry      <= '0;
      end
      if (grant_led) begin
        owner      <= REQ_LED;
        last_grant <= REQ_LED;
        cur_byte   <= CMD_SET_LEDS;
        led_pend   <= 1'b0;
        led_error  <= 1'b0;
        led_stage  <= 1'b0;
        retry      <= '0;
      end
      // A request in the grant cycle must survive the clear above.
      if (led_req) led_pend <= 1'b1;

      if (boot_go) begin
        owner    <= REQ_BOOT;
        cur_byte <= CMD_RESET;
        retry    <= '0;
      end
      if (retry_inc) retry <= retry + RW'(1);
      if (led_step) begin
        cur_byte  <= {5'b0, led_state};
        led_stage <= 1'b1;
        retry     <= '0;
      end

      if (state == S_DONE && owner == REQ_CPU) cpu_busy <= 1'b0;
      if (state == S_ERR) begin
        if (owner == REQ_CPU) begin
          cpu_error <= 1'b1;
          cpu_busy  <= 1'b0;
        end else if (owner == REQ_LED) begin
          led_error <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rx_pass = 1'b1;
    if (rx_valid && state == S_RSP_WAIT && (rx_code == RSP_ACK || rx_code == RSP_RESEND))
      rx_pass = 1'b0;
`ifdef PS2_BOOT_RESET_EN
    if (rx_valid && state == S_BAT_WAIT && rx_code == RSP_BAT)
      rx_pass = 1'b0;
`endif
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Scoreboard bench: expected transmitter bytes and keyboard replies are
// planned per request; a monitor checks every tx_load against the queue.
module tb_ps2_cmd_scheduler;

  localparam int TO   = 200;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_data;
  logic       cpu_load;
  logic       cpu_busy, cpu_error;
  logic [2:0] led_state;
  logic       led_req;
  logic       led_error;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_busy, tx_error;
  logic       rx_valid;
  logic [7:0] rx_code;
  logic       rx_pass, busy;

  ps2_cmd_scheduler #(.TIMEOUT_CYCLES(TO), .START_CYCLES(16), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .cpu_data(cpu_data), .cpu_load(cpu_load),
    .cpu_busy(cpu_busy), .cpu_error(cpu_error), .led_state(led_state),
    .led_req(led_req), .led_error(led_error), .tx_data(tx_data),
    .tx_load(tx_load), .tx_busy(tx_busy), .tx_error(tx_error),
    .rx_valid(rx_valid), .rx_code(rx_code), .rx_pass(rx_pass), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    bit         respond;
    bit         noise;
    logic [7:0] nz;
    int         txlen;
  } plan_t;

  logic [7:0] exp_tx[$];
  plan_t      plan[$];
  int  n_cmp = 0, n_fail = 0, n_loads = 0;
  bit  resp_active = 0;
  int  rr_last;             // 0 = CPU, 1 = LED; CPU wins the first tie after reset
  bit  exp_cpu_err, exp_led_err;
  int  force_txlen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every transmitter load must match the next planned byte.
  always @(posedge clk) begin
    #1;
    if (tx_load === 1'b1) begin
      n_loads++;
      if (exp_tx.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL tx_load_unexpected: got data %02h want no load", tx_data);
      end else begin
        chk("tx_data", tx_data, exp_tx.pop_front());
      end
    end
  end

  task automatic send_rx(input logic [7:0] c, input bit exp_pass, input string nm);
    rx_valid = 1'b1;
    rx_code  = c;
    #1;
    chk(nm, rx_pass, exp_pass);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Transmitter + keyboard model driven by the plan queue.
  initial begin
    plan_t pe;
    tx_busy = 0; tx_error = 0; rx_valid = 0; rx_code = 0;
    forever begin
      @(posedge clk); #1;
      if (tx_load === 1'b1 && !rst) begin
        resp_active = 1;
        if (plan.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_load_unplanned: got load want none");
          pe = '{8'h00, 1'b0, 1'b0, 8'h00, 5};
        end else pe = plan.pop_front();
        @(negedge clk); tx_busy = 1;
        repeat (pe.txlen) @(negedge clk);
        tx_busy = 0;
        repeat (2) @(negedge clk);
        if (pe.noise) send_rx(pe.nz, 1'b1, "rx_pass_noise");
        if (pe.respond) send_rx(pe.code, 1'b0, "rx_pass_rsp");
        resp_active = 0;
      end
    end
  end

  task automatic push_plan(input logic [7:0] c, input bit resp);
    plan_t p;
    p.code = c; p.respond = resp;
    p.noise = ($urandom_range(0, 9) < 3);
    p.nz = 8'($urandom_range(0, 8'hA9));
    p.txlen = (force_txlen != 0) ? force_txlen : $urandom_range(3, 30);
    plan.push_back(p);
  endtask

  // One byte: nfe resends then ack (or silence if nr); too many resends fail.
  task automatic plan_byte(input logic [7:0] b, input int nfe, input bit nr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= nfe; i++) begin
      exp_tx.push_back(b);
      if (i < nfe) begin
        push_plan(8'hFE, 1'b1);
        if (i == MAXR) return;
      end else begin
        push_plan(8'hFA, !nr);
        ok = !nr;
      end
    end
  endtask

  task automatic serve_cpu(input logic [7:0] b, input int nfe, input bit nr);
    bit ok;
    plan_byte(b, nfe, nr, ok);
    exp_cpu_err = !ok;
    rr_last = 0;
  endtask

  task automatic serve_led(input int n1, input bit r1, input int n2, input bit r2);
    bit ok;
    plan_byte(8'hED, n1, r1, ok);
    if (ok) plan_byte({5'b0, led_state}, n2, r2, ok);
    exp_led_err = !ok;
    rr_last = 1;
  endtask

  task automatic issue(input bit c, input bit l, input logic [7:0] b);
    @(negedge clk);
    cpu_data = b; cpu_load = c; led_req = l;
    @(negedge clk);
    cpu_load = 0; led_req = 0;
  endtask

  task automatic wait_quiet(input int budget, input string nm);
    int q = 0, n = 0;
    while (q < 3 && n < budget) begin
      @(posedge clk); #2;
      n++;
      if (!busy && exp_tx.size() == 0 && plan.size() == 0 && !resp_active) q++;
      else q = 0;
    end
    n_cmp++;
    if (q < 3) begin
      n_fail++;
      $display("FAIL %s_quiet: got still busy after %0d cycles want idle", nm, budget);
      exp_tx.delete();
    end
  endtask

  task automatic end_checks(input string nm);
    chk({nm, "_cpu_error"}, cpu_error, exp_cpu_err);
    chk({nm, "_led_error"}, led_error, exp_led_err);
    chk({nm, "_cpu_busy"}, cpu_busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    rr_last = 1; exp_cpu_err = 0; exp_led_err = 0;
  endtask

  task automatic pick(output int nfe, output bit nr);
    int r = $urandom_range(0, 9);
    nfe = 0; nr = 0;
    if (r >= 4 && r <= 6) nfe = $urandom_range(1, 2);
    else if (r == 7) nfe = MAXR + 1;
    else if (r == 8) nr = 1;
  endtask

  initial begin
    int l0, n1, n2, n3;
    bit r1, r2, r3;
    logic [7:0] b;
    rst = 1; cpu_data = 0; cpu_load = 0; led_state = 0; led_req = 0;
    do_reset();
    @(posedge clk); #1;
    chk("rst_cpu_busy", cpu_busy, 0);
    chk("rst_cpu_error", cpu_error, 0);
    chk("rst_led_error", led_error, 0);
    chk("rst_tx_load", tx_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 8'h00);

    // CPU byte with a long transmit and load latency check.
    force_txlen = 1000;
    serve_cpu(8'hF4, 0, 0);
    force_txlen = 0;
    @(negedge clk); cpu_data = 8'hF4; cpu_load = 1;
    @(posedge clk); #1; cpu_load = 0;
    chk("lat_cpu_busy", cpu_busy, 1);
    @(posedge clk); #1; chk("lat_n1_tx_load", tx_load, 0);
    @(posedge clk); #1; chk("lat_n2_tx_load", tx_load, 1);
    wait_quiet(3000, "cpu1");
    end_checks("cpu1");

    // LED update with a scancode interleaved while awaiting the ack.
    led_state = 3'b101;
    serve_led(0, 0, 0, 0);
    plan[0].noise = 1; plan[0].nz = 8'h1C;
    issue(0, 1, 8'h00);
    wait_quiet(2000, "led1");
    end_checks("led1");

    // Collisions: fresh reset, then again after a CPU-only grant.
    do_reset();
    led_state = 3'b010;
    if (rr_last == 1) begin serve_cpu(8'hF3, 0, 0); serve_led(0, 0, 0, 0); end
    else begin serve_led(0, 0, 0, 0); serve_cpu(8'hF3, 0, 0); end
    issue(1, 1, 8'hF3);
    wait_quiet(2000, "coll1");
    end_checks("coll1");
    serve_cpu(8'h20, 0, 0);
    issue(1, 0, 8'h20);
    wait_quiet(2000, "cpu2");
    if (rr_last == 1) begin serve_cpu(8'h31, 0, 0); serve_led(0, 0, 0, 0); end
    else begin serve_led(0, 0, 0, 0); serve_cpu(8'h31, 0, 0); end
    issue(1, 1, 8'h31);
    wait_quiet(2000, "coll2");
    end_checks("coll2");

    // Resend exhaustion on a CPU byte.
    serve_cpu(8'hED, 4, 0);
    l0 = n_loads;
    issue(1, 0, 8'hED);
    wait_quiet(3000, "retry");
    chk("retry_loads", n_loads - l0, MAXR + 1);
    chk("retry_cpu_error", cpu_error, 1);

    // Response timeout on the LED sequence, then a clean retry.
    serve_led(0, 1, 0, 0);
    issue(0, 1, 8'h00);
    wait_quiet(TO + 500, "ledto");
    chk("ledto_led_error", led_error, 1);
    led_state = 3'b011;
    serve_led(0, 0, 0, 0);
    issue(0, 1, 8'h00);
    wait_quiet(2000, "led2");
    chk("led2_led_error", led_error, 0);

    // Reset while waiting for a response.
    serve_cpu(8'h55, 0, 1);
    issue(1, 0, 8'h55);
    for (int i = 0; i < 300 && (plan.size() != 0 || resp_active); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rstmid_busy_before", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cpu_busy", cpu_busy, 0);
    @(negedge clk); rst = 0;
    rr_last = 1; exp_cpu_err = 0; exp_led_err = 0;
    @(negedge clk);
    send_rx(8'hFA, 1'b1, "rstmid_rx_pass");

    // Randomized request mix.
    for (int t = 0; t < 12; t++) begin
      int k = $urandom_range(0, 2);
      b = 8'($urandom);
      led_state = 3'($urandom);
      pick(n1, r1); pick(n2, r2); pick(n3, r3);
      if (k == 0) serve_cpu(b, n1, r1);
      else if (k == 1) serve_led(n2, r2, n3, r3);
      else if (rr_last == 1) begin serve_cpu(b, n1, r1); serve_led(n2, r2, n3, r3); end
      else begin serve_led(n2, r2, n3, r3); serve_cpu(b, n1, r1); end
      issue(k != 1, k != 0, b);
      wait_quiet(4000, "rand");
      end_checks("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_scheduler.md
Name: ps2_cmd_scheduler

Overview:
- Sequences and shares the single PS/2 host-to-keyboard transmitter between two requesters: CPU command writes and the lock-LED updater.
- The LED updater issues the two-byte sequence 0xED then the LED byte.
- For each byte sent, the block tracks the keyboard's response (0xFA ack, 0xFE resend) with retry and timeout.
- It consumes protocol responses so they never reach the scancode translator. Sits between the ZX-Uno register interface, the PS/2 transmitter and the PS/2 receiver.

Parameters:
- TIMEOUT_CYCLES, 560000: clock cycles allowed for a keyboard response (20 ms at 28 MHz). Counter width is clog2(TIMEOUT_CYCLES+1).
- START_CYCLES, 16: cycles allowed between tx_load and tx_busy rising.
- MAX_RETRY, 3: resends allowed per byte on 0xFE before an error is declared.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_data  in  8  command byte from CPU register write
- cpu_load  in  1  one-cycle pulse: CPU byte valid
- cpu_busy  out  1  CPU request pending or in service
- cpu_error  out  1  last CPU byte failed; sticky until next accepted cpu_load
- led_state  in  3  {scroll,num,caps} current lock state
- led_req  in  1  one-cycle pulse: LED update wanted
- led_error  out  1  last LED sequence failed; sticky until next LED grant
- tx_data  out  8  byte to transmitter
- tx_load  out  1  one-cycle load strobe to transmitter
- tx_busy  in  1  transmitter busy
- tx_error  in  1  transmitter reports failure (valid when tx_busy falls)
- rx_valid  in  1  one-cycle pulse: byte received
- rx_code  in  8  received byte
- rx_pass  out  1  combinational: 1 = forward this rx byte to the translator
- busy  out  1  state is not IDLE

Behaviour:
- Reset: state IDLE; all pending flags, retry count and timers cleared. cpu_busy, cpu_error, led_error, tx_load, busy = 0; tx_data = 0x00.
- Reset mid-operation abandons the sequence immediately; an in-flight transmitter frame is not aborted.
- Request capture:
  - cpu_load while cpu_busy=0 latches cpu_data and sets cpu_pend; cpu_busy rises the next cycle.
  - cpu_load while cpu_busy=1 is ignored.
  - led_req sets led_pend at any time, including during an LED sequence; this forces one further sequence afterwards.
  - led_state is sampled when the LED byte is loaded, not at request time.
- Arbitration in IDLE: round-robin when both requests are pending, with the last-granted requester losing the tie; otherwise the sole pending requester wins. The grant clears that requester's pend flag, except the CPU, which stays busy until the sequence completes.
- Latency: cpu_load at edge N produces tx_load high during cycle N+2.
- States:
  - IDLE: grant a requester, then go to LOAD.
  - LOAD: tx_load=1 for exactly one cycle with tx_data valid, then go to TX_START.
  - TX_START: wait for tx_busy=1. If START_CYCLES elapse first, go to ERR.
  - TX_END: wait for tx_busy=0. If tx_error=1 at that point, go to ERR; otherwise clear the timer and go to RSP_WAIT.
  - RSP_WAIT, on an rx_valid byte:
    - 0xFA: go to NEXT.
    - 0xFE: if retry < MAX_RETRY, increment retry and go to LOAD with the same byte; otherwise go to ERR.
    - Any other byte: pass it through and keep waiting. The timer is not reset.
    - If the timer reaches TIMEOUT_CYCLES, go to ERR.
  - NEXT: if the LED sequence has just acked 0xED, load {5'b0,led_state}, clear retry and go to LOAD. Otherwise go to DONE.
  - DONE: clear cpu_busy if the CPU owned the sequence, then go to IDLE.
  - ERR: set the owner's error flag, clear cpu_busy if applicable, drop the rest of the sequence, and go to IDLE.
- rx_pass = 0 only when rx_valid=1 and state=RSP_WAIT and rx_code ∈ {0xFA, 0xFE}; it is 1 otherwise. Bytes arriving outside RSP_WAIT always pass.
- An rx_valid in the same cycle as the timeout is handled as the byte, not as the timeout.

Optional Feature:
- PS2_BOOT_RESET_EN defined: after rst the block enters BOOT and sends 0xFF using the same LOAD/TX/RSP path.
  - After 0xFA it waits up to TIMEOUT_CYCLES×50 for 0xAA. That 0xAA is consumed (rx_pass=0).
  - Requests are latched but not granted until BOOT completes or fails. A failure sets no error flag.
- Undefined: the block leaves reset directly in IDLE.

Decomposition:
- Shared package ps2_cmd_pkg holds:
  - state encodings;
  - constants CMD_SET_LEDS=0xED, CMD_RESET=0xFF, RSP_ACK=0xFA, RSP_RESEND=0xFE, RSP_BAT=0xAA;
  - requester IDs.
- One sub-module, ps2_rsp_timer: a loadable down-counter with clear/start inputs and an expired output, used for both the START and RSP timeouts.

Test Plan:
- cpu_load 0xF4; tx_busy pulses high for 1000 cycles; then rx 0xFA → tx_load in cycle N+2 with tx_data=0xF4; rx_pass=0 for the 0xFA; cpu_busy falls; cpu_error=0.
- led_req with led_state=3'b101 → tx_data 0xED, ack, then 0x05, ack; led_error=0. A scancode 0x1C received during RSP_WAIT has rx_pass=1.
- cpu_load and led_req in the same cycle, reset-fresh → a single clean winner is granted and the other requester is served immediately after; a repeat collision alternates the winner.
- Response 0xFE four times to cpu byte 0xED → exactly 4 tx_load pulses, then cpu_error=1.
- No response after transmit → ERR after TIMEOUT_CYCLES; led_error=1; a second led_req then retries cleanly.
- rst asserted during RSP_WAIT → the next cycle shows busy=0 and cpu_busy=0; a later 0xFA has rx_pass=1.
